ball_motion: RTL and testbench

//   Per-frame ball physics. Integrates signed tilt (accelerometer) into velocity and position.

---
 rtl/ball_motion_if.sv | 11 +
 rtl/ball_motion.sv | 159 +++++++++++++++
 tb/tb_ball_motion.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_if.sv
// Wall-map probe bus between ball_motion (master) and the world-map lookup (slave).
interface ball_motion_if;
  logic       map_req;
  logic [9:0] map_addr_x;
  logic [8:0] map_addr_y;
  logic       map_ack;
  logic       map_wall;

  modport master (output map_req, map_addr_x, map_addr_y, input map_ack, map_wall);
  modport slave  (input map_req, map_addr_x, map_addr_y, output map_ack, map_wall);
endinterface

// File: rtl/ball_motion.sv
// Per-frame ball physics: tilt -> velocity -> position, with per-axis wall probes.
// One update per synchronised vert_sync falling edge; result published on COMMIT.
module ball_motion #(
  parameter int X_MAX       = 623,
  parameter int Y_MAX       = 463,
  parameter int X_INIT      = 16,
  parameter int Y_INIT      = 16,
  parameter int VEL_SHIFT   = 2,
  parameter int VMAX        = 31,
  parameter int MAP_TIMEOUT = 15
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              vert_sync,
  input  logic signed [7:0] accel_x,
  input  logic signed [7:0] accel_y,
  ball_motion_if.master     map,
  output logic [9:0]        ball_loc_X,
  output logic [8:0]        ball_loc_Y,
  output logic              frame_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] VEL     = 3'd1;
  localparam logic [2:0] PROBE_X = 3'd2;
  localparam logic [2:0] PROBE_Y = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;

  localparam int TW = $clog2(MAP_TIMEOUT + 1);
  localparam logic signed [11:0] VMAX_S  = 12'(VMAX);
  localparam logic signed [11:0] XMAX_S  = 12'(X_MAX);
  localparam logic signed [11:0] YMAX_S  = 12'(Y_MAX);
  localparam logic [TW-1:0]      TMO_END = TW'(MAP_TIMEOUT - 1);

  logic [2:0]        state;
  logic              vs_meta, vs_sync, vs_prev;
  logic              tick;
  logic signed [7:0] vel_x, vel_y;
  logic [9:0]        cand_x, new_x;
  logic [8:0]        cand_y, new_y;
  logic [TW-1:0]     tmo_cnt;

  logic signed [11:0] step_x, step_y, sum_x, sum_y, raw_x, raw_y;
  logic signed [7:0]  nvx, nvy;
  logic [9:0]         ncx;
  logic [8:0]         ncy;
  logic               probe_done, probe_wall;

  function automatic logic signed [11:0] sat_vel(input logic signed [11:0] v);
    if (v > VMAX_S)       return VMAX_S;
    else if (v < -VMAX_S) return -VMAX_S;
    else                  return v;
  endfunction

  assign tick = vs_prev & ~vs_sync;

  // Accel is consumed directly in the single VEL cycle, equivalent to latching it there.
  always_comb begin
    step_x = 12'(accel_x) >>> VEL_SHIFT;
    step_y = 12'(accel_y) >>> VEL_SHIFT;
    sum_x  = sat_vel(12'(vel_x) + step_x);
    sum_y  = sat_vel(12'(vel_y) + step_y);
    raw_x  = $signed({2'b00, ball_loc_X}) + sum_x;
    raw_y  = $signed({3'b000, ball_loc_Y}) + sum_y;
    nvx    = sum_x[7:0];
    nvy    = sum_y[7:0];
    ncx    = raw_x[9:0];
    ncy    = raw_y[8:0];
    if (raw_x < 12'sd0) begin
      ncx = '0;
      nvx = '0;
    end else if (raw_x > XMAX_S) begin
      ncx = XMAX_S[9:0];
      nvx = '0;
    end
    if (raw_y < 12'sd0) begin
      ncy = '0;
      nvy = '0;
    end else if (raw_y > YMAX_S) begin
      ncy = YMAX_S[8:0];
      nvy = '0;
    end
  end

  // An ack on the final timeout cycle still wins over the implied wall.
  assign probe_done = map.map_ack || (tmo_cnt == TMO_END);
  assign probe_wall = map.map_ack ? map.map_wall : 1'b1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= IDLE;
      vs_meta        <= 1'b1;
      vs_sync        <= 1'b1;
      vs_prev        <= 1'b1;
      vel_x          <= '0;
      vel_y          <= '0;
      cand_x         <= '0;
      cand_y         <= '0;
      new_x          <= '0;
      new_y          <= '0;
      tmo_cnt        <= '0;
      map.map_req    <= 1'b0;
      map.map_addr_x <= '0;
      map.map_addr_y <= '0;
      ball_loc_X     <= 10'(X_INIT);
      ball_loc_Y     <= 9'(Y_INIT);
      frame_done     <= 1'b0;
    end else begin
      vs_meta    <= vert_sync;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (tick) state <= VEL;
        VEL: begin
          vel_x          <= nvx;
          vel_y          <= nvy;
          cand_x         <= ncx;
          cand_y         <= ncy;
          map.map_req    <= 1'b1;
          map.map_addr_x <= ncx;
          map.map_addr_y <= ball_loc_Y;
          tmo_cnt        <= '0;
          state          <= PROBE_X;
        end
        PROBE_X: begin
          if (probe_done) begin
            new_x          <= probe_wall ? ball_loc_X : cand_x;
            if (probe_wall) vel_x <= '0;
            map.map_addr_x <= probe_wall ? ball_loc_X : cand_x;
            map.map_addr_y <= cand_y;
            tmo_cnt        <= '0;
            state          <= PROBE_Y;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        PROBE_Y: begin
          if (probe_done) begin
            new_y       <= probe_wall ? ball_loc_Y : cand_y;
            if (probe_wall) vel_y <= '0;
            map.map_req <= 1'b0;
            state       <= COMMIT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        COMMIT: begin
          ball_loc_X <= new_x;
          ball_loc_Y <= new_y;
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: randomized tilt and wall maps against a behavioural model.
module tb_ball_motion;
  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              vert_sync = 1'b1;
  logic signed [7:0] accel_x = '0;
  logic signed [7:0] accel_y = '0;
  logic [9:0]        ball_loc_X;
  logic [8:0]        ball_loc_Y;
  logic              frame_done;

  ball_motion_if bus ();

  ball_motion dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .vert_sync (vert_sync),
    .accel_x   (accel_x),
    .accel_y   (accel_y),
    .map       (bus),
    .ball_loc_X(ball_loc_X),
    .ball_loc_Y(ball_loc_Y),
    .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  // Map responder configuration and observation log
  int resp_delay = 0;
  bit resp_noack = 0;
  int wall_mode = 0;      // 0 open, 1 random walls, 2 wall on X probe only
  int cnt = 0;
  bit prev_ack = 0;
  int probe_idx = 0;
  int plog_x[4], plog_y[4];
  bit plog_w[4];
  int req_cycles = 0;
  int done_count = 0;
  int addr0_x, addr0_y, addr15_x, addr15_y;
  int held_x, held_y;

  // Behavioural model state
  int mx = 16, my = 16, mvx = 0, mvy = 0;

  always @(negedge sys_clk) begin
    bit w;
    if (sys_rst) begin
      cnt = 0;
      prev_ack = 0;
      bus.map_ack = 1'b0;
      bus.map_wall = 1'b0;
    end else begin
      if (prev_ack) cnt = 0;
      if (bus.map_req) begin
        if (req_cycles == 0) begin addr0_x = int'(bus.map_addr_x); addr0_y = int'(bus.map_addr_y); end
        if (req_cycles == 15) begin addr15_x = int'(bus.map_addr_x); addr15_y = int'(bus.map_addr_y); end
        req_cycles++;
        if (cnt > 0 && !(resp_noack && cnt == 15)) begin
          checks++;
          if (int'(bus.map_addr_x) !== held_x || int'(bus.map_addr_y) !== held_y) begin
            failures++;
            $display("FAIL addr_stable: got (%0d,%0d) expected (%0d,%0d)",
                     bus.map_addr_x, bus.map_addr_y, held_x, held_y);
          end
        end
        held_x = int'(bus.map_addr_x);
        held_y = int'(bus.map_addr_y);
        if (!resp_noack && cnt >= resp_delay) begin
          w = (wall_mode == 1) ? ($urandom_range(0, 3) == 0) :
              (wall_mode == 2) ? (probe_idx == 0) : 1'b0;
          bus.map_ack = 1'b1;
          bus.map_wall = w;
          if (probe_idx < 4) begin
            plog_x[probe_idx] = int'(bus.map_addr_x);
            plog_y[probe_idx] = int'(bus.map_addr_y);
            plog_w[probe_idx] = w;
          end
          probe_idx++;
        end else begin
          bus.map_ack = 1'b0;
          bus.map_wall = 1'($urandom_range(0, 1));
        end
        cnt++;
      end else begin
        cnt = 0;
        // stray acks outside a probe must be ignored
        bus.map_ack = 1'($urandom_range(0, 1));
        bus.map_wall = 1'($urandom_range(0, 1));
      end
      prev_ack = bus.map_ack && bus.map_req;
    end
    if (frame_done === 1'b1) done_count++;
  end

  function automatic int fdiv4(input int a);
    return (a - (((a % 4) + 4) % 4)) / 4;
  endfunction

  function automatic int sat(input int v);
    return (v > 31) ? 31 : (v < -31) ? -31 : v;
  endfunction

  task automatic model_reset();
    mx = 16; my = 16; mvx = 0; mvy = 0;
  endtask

  task automatic check_frame(input int ax, input int ay, input bit timeout, input string tag);
    int vx, vy, cx, cy, nx, ny, a0x, a0y, a1x, a1y;
    bit w0, w1;
    vx = sat(mvx + fdiv4(ax));
    vy = sat(mvy + fdiv4(ay));
    cx = mx + vx;
    cy = my + vy;
    if (cx < 0) begin cx = 0; vx = 0; end else if (cx > 623) begin cx = 623; vx = 0; end
    if (cy < 0) begin cy = 0; vy = 0; end else if (cy > 463) begin cy = 463; vy = 0; end
    if (timeout) begin
      w0 = 1; w1 = 1;
      a0x = addr0_x; a0y = addr0_y; a1x = addr15_x; a1y = addr15_y;
    end else begin
      checks++;
      if (probe_idx !== 2) begin
        failures++;
        $display("FAIL %s probe_count: got %0d expected 2", tag, probe_idx);
      end
      w0 = plog_w[0]; w1 = plog_w[1];
      a0x = plog_x[0]; a0y = plog_y[0]; a1x = plog_x[1]; a1y = plog_y[1];
    end
    checks++;
    if (a0x !== cx || a0y !== my) begin
      failures++;
      $display("FAIL %s probe_x_addr: got (%0d,%0d) expected (%0d,%0d)", tag, a0x, a0y, cx, my);
    end
    nx = w0 ? mx : cx;
    if (w0) vx = 0;
    checks++;
    if (a1x !== nx || a1y !== cy) begin
      failures++;
      $display("FAIL %s probe_y_addr: got (%0d,%0d) expected (%0d,%0d)", tag, a1x, a1y, nx, cy);
    end
    ny = w1 ? my : cy;
    if (w1) vy = 0;
    mx = nx; my = ny; mvx = vx; mvy = vy;
    checks++;
    if (int'(ball_loc_X) !== mx || int'(ball_loc_Y) !== my) begin
      failures++;
      $display("FAIL %s position: got (%0d,%0d) expected (%0d,%0d)", tag, ball_loc_X, ball_loc_Y, mx, my);
    end
  endtask

  // Drops vert_sync, waits for frame_done, checks latency (if exp_lat>0) and pulse width.
  task automatic run_frame(input int ax, input int ay, input int exp_lat, input string tag);
    int lat;
    accel_x = 8'(ax);
    accel_y = 8'(ay);
    probe_idx = 0;
    req_cycles = 0;
    @(negedge sys_clk);
    vert_sync = 1'b0;
    lat = 0;
    while (frame_done !== 1'b1 && lat < 200) begin
      @(negedge sys_clk);
      lat++;
      if (lat == 4) vert_sync = 1'b1;
    end
    vert_sync = 1'b1;
    checks++;
    if (lat >= 200) begin
      failures++;
      $display("FAIL %s frame_done_timeout: got none expected pulse within 200 cycles", tag);
    end
    if (exp_lat > 0) begin
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
      end
    end
    @(negedge sys_clk);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL %s frame_done_width: got %0b expected 0", tag, frame_done);
    end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (ball_loc_X !== 10'd16 || ball_loc_Y !== 9'd16 || bus.map_req !== 1'b0 || frame_done !== 1'b0 ||
        bus.map_addr_x !== 10'd0 || bus.map_addr_y !== 9'd0) begin
      failures++;
      $display("FAIL reset_state: got loc=(%0d,%0d) req=%0b done=%0b addr=(%0d,%0d) expected (16,16) 0 0 (0,0)",
               ball_loc_X, ball_loc_Y, bus.map_req, frame_done, bus.map_addr_x, bus.map_addr_y);
    end
    sys_rst = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_latency();
    resp_delay = 0; wall_mode = 0; resp_noack = 0;
    run_frame(0, 0, 7, "latency");
    check_frame(0, 0, 0, "latency");
  endtask

  task automatic test_accel_x();
    int exp_x[3] = '{21, 31, 46};
    resp_delay = 0; wall_mode = 0;
    for (int i = 0; i < 3; i++) begin
      run_frame(20, 0, 7, "accel_x");
      check_frame(20, 0, 0, "accel_x");
      checks++;
      if (int'(ball_loc_X) !== exp_x[i] || ball_loc_Y !== 9'd16) begin
        failures++;
        $display("FAIL accel_x_step%0d: got (%0d,%0d) expected (%0d,16)", i, ball_loc_X, ball_loc_Y, exp_x[i]);
      end
    end
  endtask

  task automatic test_reset_mid_probe();
    int n;
    resp_delay = 10; wall_mode = 0;
    accel_x = 8'sd12; accel_y = 8'sd12;
    probe_idx = 0; req_cycles = 0;
    @(negedge sys_clk);
    vert_sync = 1'b0;
    n = 0;
    while (bus.map_req !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (bus.map_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_probe_req: got %0b expected 1", bus.map_req);
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    checks++;
    if (bus.map_req !== 1'b0 || ball_loc_X !== 10'd16 || ball_loc_Y !== 9'd16) begin
      failures++;
      $display("FAIL rst_mid_probe: got req=%0b loc=(%0d,%0d) expected 0 (16,16)", bus.map_req, ball_loc_X, ball_loc_Y);
    end
    vert_sync = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    resp_delay = 0;
    run_frame(8, -8, 7, "after_rst");
    check_frame(8, -8, 0, "after_rst");
  endtask

  task automatic test_clamp_right();
    resp_delay = 0; wall_mode = 0;
    for (int i = 0; i < 40 && mx != 623; i++) begin
      run_frame(127, 0, 7, "clamp_r");
      check_frame(127, 0, 0, "clamp_r");
    end
    checks++;
    if (ball_loc_X !== 10'd623) begin
      failures++;
      $display("FAIL clamp_right: got %0d expected 623", ball_loc_X);
    end
    run_frame(0, 0, 7, "clamp_r_rest");
    check_frame(0, 0, 0, "clamp_r_rest");
  endtask

  task automatic test_clamp_left();
    for (int i = 0; i < 40 && mx != 0; i++) begin
      run_frame(-128, 0, 7, "clamp_l");
      check_frame(-128, 0, 0, "clamp_l");
    end
    checks++;
    if (ball_loc_X !== 10'd0) begin
      failures++;
      $display("FAIL clamp_left: got %0d expected 0", ball_loc_X);
    end
    run_frame(0, 0, 7, "clamp_l_rest");
    check_frame(0, 0, 0, "clamp_l_rest");
  endtask

  task automatic test_wall_x();
    int old_x, old_y;
    wall_mode = 2; resp_delay = 2;
    old_x = mx; old_y = my;
    run_frame(60, 60, 0, "wall_x");
    check_frame(60, 60, 0, "wall_x");
    checks++;
    if (int'(ball_loc_X) !== old_x || int'(ball_loc_Y) === old_y || plog_x[1] !== old_x) begin
      failures++;
      $display("FAIL wall_x: got x=%0d y=%0d yprobe_x=%0d expected x=%0d y!=%0d yprobe_x=%0d",
               ball_loc_X, ball_loc_Y, plog_x[1], old_x, old_y, old_x);
    end
    wall_mode = 0;
  endtask

  task automatic test_timeout();
    int d0, old_x, old_y;
    resp_noack = 1;
    old_x = mx; old_y = my;
    d0 = done_count;
    run_frame(40, 40, 0, "timeout");
    check_frame(40, 40, 1, "timeout");
    repeat (20) @(negedge sys_clk);
    checks++;
    if (req_cycles !== 30) begin
      failures++;
      $display("FAIL timeout_req_cycles: got %0d expected 30", req_cycles);
    end
    checks++;
    if (done_count - d0 !== 1 || int'(ball_loc_X) !== old_x || int'(ball_loc_Y) !== old_y) begin
      failures++;
      $display("FAIL timeout_frame: got done=%0d loc=(%0d,%0d) expected 1 (%0d,%0d)",
               done_count - d0, ball_loc_X, ball_loc_Y, old_x, old_y);
    end
    resp_noack = 0;
  endtask

  task automatic test_dropped_tick();
    int d0, n;
    resp_delay = 10; wall_mode = 0;
    accel_x = 8'sd12; accel_y = -8'sd12;
    probe_idx = 0; req_cycles = 0;
    d0 = done_count;
    @(negedge sys_clk);
    vert_sync = 1'b0;
    repeat (3) @(negedge sys_clk);
    vert_sync = 1'b1;
    n = 0;
    while (probe_idx < 1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    vert_sync = 1'b0;
    repeat (3) @(negedge sys_clk);
    vert_sync = 1'b1;
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL drop_tick_timeout: got none expected frame_done");
    end
    check_frame(12, -12, 0, "drop_tick");
    repeat (40) @(negedge sys_clk);
    checks++;
    if (done_count - d0 !== 1) begin
      failures++;
      $display("FAIL drop_tick_pulses: got %0d expected 1", done_count - d0);
    end
    resp_delay = 0;
  endtask

  task automatic test_random();
    int ax, ay;
    wall_mode = 1;
    for (int i = 0; i < 25; i++) begin
      resp_delay = $urandom_range(0, 3);
      ax = int'($urandom_range(0, 255)) - 128;
      ay = int'($urandom_range(0, 255)) - 128;
      run_frame(ax, ay, 0, "random");
      check_frame(ax, ay, 0, "random");
    end
    wall_mode = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_accel_x();
    test_reset_mid_probe();
    test_clamp_right();
    test_clamp_left();
    test_wall_x();
    test_timeout();
    test_dropped_tick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
